// File: rtl/gg_emit_slice_rowslice.sv
// rtl/gg_emit_slice_rowslice.sv - single-row slice_layer_rbsp() writer with big-endian word packer
// Header, skip-run/MB alternation and rbsp trailing bits are fed one field per cycle into a WIDTH+32 bit accumulator.
module gg_emit_slice_rowslice #(
  parameter int WIDTH      = 32,
  parameter int BYTE_WIDTH = WIDTH / 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            slice_start,
  input  logic [15:0]                     first_mb,
  input  logic [3:0]                      slice_type,
  input  logic [7:0]                      pps_id,
  input  logic [3:0]                      frame_num,
  input  logic [3:0]                      poc_lsb,
  input  logic [6:0]                      qp_delta,
  input  logic [1:0]                      dblk_idc,
  input  logic [3:0]                      dblk_alpha,
  input  logic [3:0]                      dblk_beta,
  output logic                            busy,
  input  logic                            mb_valid,
  output logic                            mb_ready,
  input  logic                            mb_skip,
  input  logic [31:0]                     mb_data,
  input  logic [5:0]                      mb_len,
  input  logic                            mb_end,
  input  logic                            mb_row_last,
  output logic [WIDTH-1:0]                out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic [$clog2(BYTE_WIDTH):0]     out_bytes
);

  localparam int AW = WIDTH + 32;
  localparam int FW = $clog2(AW + 1);
  localparam int BW = $clog2(BYTE_WIDTH) + 1;
  localparam logic [FW-1:0] WIDTH_F = FW'(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_MBS, S_PAY, S_RUNEND, S_TRAIL, S_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [3:0]      hdr_idx_q, hdr_idx_d;
  logic [15:0]     skip_cnt_q, skip_cnt_d;
  logic [AW-1:0]   acc_q, acc_d, acc_ap;
  logic [FW-1:0]   fill_q, fill_d, fill_ap;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [BW-1:0]   out_bytes_q, out_bytes_d;
  logic [15:0]     fmb_q, fmb_d;
  logic [3:0]      st_q, st_d, fn_q, fn_d, poc_q, poc_d, alpha_q, alpha_d, beta_q, beta_d;
  logic [7:0]      pps_q, pps_d;
  logic [6:0]      qp_q, qp_d;
  logic [1:0]      idc_q, idc_d;

  logic            room, push_en, use_ue, pop, last_pop;
  logic [15:0]     ue_v, vp1;
  logic [31:0]     raw_lj, push_lj;
  logic [5:0]      raw_len, push_len;

  function automatic logic [5:0] ue_len(input logic [15:0] x);
    logic [5:0] m;
    m = 6'd0;
    for (int i = 0; i < 16; i++) if (x[i]) m = 6'(i);
    return (m << 1) + 6'd1;
  endfunction

  function automatic logic [15:0] se_map(input logic [15:0] s);
    if (!s[15] && (s != 16'd0)) return (s << 1) - 16'd1;
    return (16'd0 - s) << 1;
  endfunction

  assign room = (fill_q <= WIDTH_F);

  always_comb begin
    state_d = state_q;  hdr_idx_d = hdr_idx_q;  skip_cnt_d = skip_cnt_q;
    fmb_d = fmb_q;  st_d = st_q;  pps_d = pps_q;  fn_d = fn_q;  poc_d = poc_q;
    qp_d = qp_q;  idc_d = idc_q;  alpha_d = alpha_q;  beta_d = beta_q;
    mb_ready = 1'b0;  push_en = 1'b0;  use_ue = 1'b0;
    ue_v = 16'd0;  raw_lj = 32'd0;  raw_len = 6'd1;
    case (state_q)
      S_IDLE: if (slice_start) begin
        fmb_d = first_mb;  st_d = slice_type;  pps_d = pps_id;  fn_d = frame_num;
        poc_d = poc_lsb;  qp_d = qp_delta;  idc_d = dblk_idc;
        alpha_d = dblk_alpha;  beta_d = dblk_beta;
        hdr_idx_d = 4'd0;  state_d = S_HDR;
      end
      S_HDR: if (room) begin
        push_en = 1'b1;
        use_ue  = 1'b1;
        case (hdr_idx_q)
          4'd0: ue_v = fmb_q;
          4'd1: ue_v = {12'd0, st_q};
          4'd2: ue_v = {8'd0, pps_q};
          4'd3: begin use_ue = 1'b0; raw_lj = {fn_q, 28'd0};  raw_len = 6'd4; end
          4'd4: begin use_ue = 1'b0; raw_lj = {poc_q, 28'd0}; raw_len = 6'd4; end
          4'd5: begin use_ue = 1'b0; raw_len = 6'd3; end
          4'd6: ue_v = se_map({{9{qp_q[6]}}, qp_q});
          4'd7: ue_v = {14'd0, idc_q};
          4'd8: ue_v = se_map({{12{alpha_q[3]}}, alpha_q});
          default: ue_v = se_map({{12{beta_q[3]}}, beta_q});
        endcase
        if ((hdr_idx_q == 4'd7 && idc_q == 2'd1) || hdr_idx_q == 4'd9) begin
          skip_cnt_d = 16'd0;
          state_d    = S_MBS;
        end else begin
          hdr_idx_d = hdr_idx_q + 4'd1;
        end
      end
      S_MBS: if (room) begin
        // A coded MB is held off for one cycle while its preceding skip run is written.
        mb_ready = !(mb_valid && !mb_skip);
        if (mb_valid && mb_skip) begin
          skip_cnt_d = skip_cnt_q + 16'd1;
          if (mb_row_last) state_d = S_RUNEND;
        end else if (mb_valid) begin
          push_en = 1'b1;  use_ue = 1'b1;  ue_v = skip_cnt_q;
          skip_cnt_d = 16'd0;
          state_d = S_PAY;
        end
      end
      S_PAY: begin
        mb_ready = room;
        if (room && mb_valid) begin
          push_en = 1'b1;
          raw_lj  = mb_data & ~(32'hFFFF_FFFF >> mb_len);
          raw_len = mb_len;
          if (mb_end) state_d = mb_row_last ? S_TRAIL : S_MBS;
        end
      end
      S_RUNEND: if (room) begin
        push_en = 1'b1;  use_ue = 1'b1;  ue_v = skip_cnt_q;
        state_d = S_TRAIL;
      end
      S_TRAIL: if (room) begin
        push_en = 1'b1;
        raw_lj  = 32'h8000_0000;
        raw_len = 6'd8 - {3'd0, fill_q[2:0]};
        state_d = S_FLUSH;
      end
      S_FLUSH: if (out_valid_q && out_ready && out_last_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    vp1 = ue_v + 16'd1;
    if (use_ue) begin
      push_len = ue_len(vp1);
      push_lj  = {16'd0, vp1} << (6'd32 - push_len);
    end else begin
      push_len = raw_len;
      push_lj  = raw_lj;
    end
  end

  always_comb begin
    pop = (!out_valid_q || out_ready) &&
          ((state_q == S_FLUSH) ? (fill_q != '0) : (fill_q >= WIDTH_F));
    last_pop    = (state_q == S_FLUSH) && (fill_q <= WIDTH_F);
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    out_last_d  = out_valid_d ? out_last_q : 1'b0;
    out_bytes_d = out_bytes_q;
    acc_ap      = acc_q;
    fill_ap     = fill_q;
    if (pop) begin
      out_data_d  = acc_q[AW-1 -: WIDTH];
      out_valid_d = 1'b1;
      out_last_d  = last_pop;
      out_bytes_d = last_pop ? BW'((fill_q + FW'(7)) >> 3) : BW'(BYTE_WIDTH);
      acc_ap      = acc_q << WIDTH;
      fill_ap     = (fill_q > WIDTH_F) ? (fill_q - WIDTH_F) : '0;
    end
    acc_d  = acc_ap;
    fill_d = fill_ap;
    if (push_en) begin
      acc_d  = acc_ap | ({push_lj, {WIDTH{1'b0}}} >> fill_ap);
      fill_d = fill_ap + {{(FW-6){1'b0}}, push_len};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;  hdr_idx_q <= '0;  skip_cnt_q <= '0;
      acc_q <= '0;  fill_q <= '0;
      out_data_q <= '0;  out_valid_q <= 1'b0;  out_last_q <= 1'b0;  out_bytes_q <= '0;
      fmb_q <= '0;  st_q <= '0;  pps_q <= '0;  fn_q <= '0;  poc_q <= '0;
      qp_q <= '0;  idc_q <= '0;  alpha_q <= '0;  beta_q <= '0;
    end else begin
      state_q <= state_d;  hdr_idx_q <= hdr_idx_d;  skip_cnt_q <= skip_cnt_d;
      acc_q <= acc_d;  fill_q <= fill_d;
      out_data_q <= out_data_d;  out_valid_q <= out_valid_d;
      out_last_q <= out_last_d;  out_bytes_q <= out_bytes_d;
      fmb_q <= fmb_d;  st_q <= st_d;  pps_q <= pps_d;  fn_q <= fn_d;  poc_q <= poc_d;
      qp_q <= qp_d;  idc_q <= idc_d;  alpha_q <= alpha_d;  beta_q <= beta_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_bytes = out_bytes_q;

endmodule

// File: tb/tb_gg_emit_slice_rowslice.sv
// tb/tb_gg_emit_slice_rowslice.sv - directed self-checking bench for gg_emit_slice_rowslice
// Words are collected at negedge; expected streams come from hand constants or a bit-queue model.
module tb_gg_emit_slice_rowslice;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0, slice_start = 1'b0;
  logic [15:0] first_mb = '0;
  logic [3:0]  slice_type = '0, frame_num = '0, poc_lsb = '0, dblk_alpha = '0, dblk_beta = '0;
  logic [7:0]  pps_id = '0;
  logic [6:0]  qp_delta = '0;
  logic [1:0]  dblk_idc = '0;
  logic        busy, mb_valid = 1'b0, mb_ready, mb_skip = 1'b0, mb_end = 1'b0, mb_row_last = 1'b0;
  logic [31:0] mb_data = '0;
  logic [5:0]  mb_len = 6'd1;
  logic [WIDTH-1:0] out_data;
  logic        out_valid, out_ready = 1'b1, out_last;
  logic [2:0]  out_bytes;

  gg_emit_slice_rowslice #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .slice_start(slice_start), .first_mb(first_mb),
    .slice_type(slice_type), .pps_id(pps_id), .frame_num(frame_num), .poc_lsb(poc_lsb),
    .qp_delta(qp_delta), .dblk_idc(dblk_idc), .dblk_alpha(dblk_alpha), .dblk_beta(dblk_beta),
    .busy(busy), .mb_valid(mb_valid), .mb_ready(mb_ready), .mb_skip(mb_skip),
    .mb_data(mb_data), .mb_len(mb_len), .mb_end(mb_end), .mb_row_last(mb_row_last),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_bytes(out_bytes)
  );

  int checks = 0, failures = 0;
  logic [31:0] got_w[$];
  logic        got_l[$];
  int          got_b[$];
  bit          eb[$];
  logic [31:0] exp_w[$];
  int          exp_b[$];

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      got_w.push_back(out_data);
      got_l.push_back(out_last);
      got_b.push_back(int'(out_bytes));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic put_u(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) eb.push_back(v[i]);
  endtask

  task automatic put_ue(input int v);
    int x = v + 1;
    int m = 0;
    while ((x >> (m + 1)) != 0) m++;
    repeat (m) eb.push_back(1'b0);
    put_u(32'(x), m + 1);
  endtask

  task automatic put_se(input int v);
    if (v > 0) put_ue(2 * v - 1);
    else put_ue(-2 * v);
  endtask

  task automatic model_hdr(input int fm, st, pps, fn, poc, qp, idc, a, b);
    eb.delete();
    put_ue(fm); put_ue(st); put_ue(pps);
    put_u(32'(fn), 4); put_u(32'(poc), 4); put_u(32'd0, 3);
    put_se(qp); put_ue(idc);
    if (idc != 1) begin put_se(a); put_se(b); end
  endtask

  task automatic model_end();
    eb.push_back(1'b1);
    while (eb.size() % 8 != 0) eb.push_back(1'b0);
    exp_w.delete(); exp_b.delete();
    for (int p = 0; p < eb.size(); p += 32) begin
      logic [31:0] w = '0;
      int n = 0;
      for (int k = 0; k < 32; k++) if (p + k < eb.size()) begin w[31-k] = eb[p+k]; n++; end
      exp_w.push_back(w);
      exp_b.push_back(n / 8);
    end
  endtask

  task automatic start_slice(input int fm, st, pps, fn, poc, qp, idc, a, b);
    got_w.delete(); got_l.delete(); got_b.delete();
    first_mb = 16'(fm); slice_type = 4'(st); pps_id = 8'(pps); frame_num = 4'(fn);
    poc_lsb = 4'(poc); qp_delta = 7'(qp); dblk_idc = 2'(idc);
    dblk_alpha = 4'(a); dblk_beta = 4'(b);
    slice_start = 1'b1;
    @(posedge clk); #1;
    slice_start = 1'b0;
  endtask

  task automatic send_beat(input logic skip, input logic [31:0] d, input int len,
                           input logic e, input logic rl, output int waited);
    logic acc = 1'b0;
    mb_valid = 1'b1; mb_skip = skip; mb_data = d; mb_len = 6'(len); mb_end = e; mb_row_last = rl;
    waited = 0;
    while (!acc && waited <= 300) begin
      @(negedge clk); acc = mb_ready;
      @(posedge clk); #1;
      if (!acc) waited++;
    end
    mb_valid = 1'b0;
    if (!acc) begin
      checks++; failures++;
      $display("FAIL beat_timeout got=not_accepted exp=accepted");
    end
  endtask

  task automatic wait_last();
    int n = 0;
    while (!(got_l.size() > 0 && got_l[got_l.size()-1]) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL last_timeout got=no_last_word exp=last_word");
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (mb_ready !== 1'b0)  begin failures++; $display("FAIL rst_mb_ready got=%b exp=0", mb_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_last !== 1'b0)  begin failures++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
    checks++; if (out_bytes !== 3'd0) begin failures++; $display("FAIL rst_out_bytes got=%0d exp=0", out_bytes); end
    checks++; if (out_data !== '0)    begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_mb(input string tag);
    int w;
    start_slice(0, 0, 0, 3, 5, 0, 1, 0, 0);
    send_beat(1'b0, 32'hA500_0000, 8, 1'b1, 1'b1, w);
    wait_last();
    checks++;
    if (got_w.size() != 1) begin
      failures++; $display("FAIL %s_count got=%0d exp=1", tag, got_w.size());
    end else begin
      checks++; if (got_w[0] !== 32'hE6A2B4B0) begin failures++; $display("FAIL %s_word got=%h exp=e6a2b4b0", tag, got_w[0]); end
      checks++; if (got_b[0] != 4)             begin failures++; $display("FAIL %s_bytes got=%0d exp=4", tag, got_b[0]); end
      checks++; if (got_l[0] !== 1'b1)         begin failures++; $display("FAIL %s_last got=%b exp=1", tag, got_l[0]); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy_after got=%b exp=0", tag, busy); end
  endtask

  task automatic test_skip_run();
    int w;
    start_slice(0, 0, 0, 3, 5, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) send_beat(1'b1, 32'hFFFF_FFFF, 1, 1'b0, (i == 4), w);
    wait_last();
    checks++;
    if (got_w.size() != 1) begin
      failures++; $display("FAIL skip_count got=%0d exp=1", got_w.size());
    end else begin
      checks++; if (got_w[0] !== 32'hE6A28D00) begin failures++; $display("FAIL skip_word got=%h exp=e6a28d00", got_w[0]); end
      checks++; if (got_b[0] != 3)             begin failures++; $display("FAIL skip_bytes got=%0d exp=3", got_b[0]); end
      checks++; if (got_l[0] !== 1'b1)         begin failures++; $display("FAIL skip_last got=%b exp=1", got_l[0]); end
    end
  endtask

  task automatic test_deblock();
    int w;
    start_slice(0, 0, 0, 3, 5, 0, 0, -1, 2);
    send_beat(1'b0, 32'hA500_0000, 8, 1'b1, 1'b1, w);
    wait_last();
    checks++;
    if (got_w.size() != 2) begin
      failures++; $display("FAIL dblk_count got=%0d exp=2", got_w.size());
    end else begin
      checks++; if (got_w[0] !== 32'hE6A364D2 || got_b[0] != 4 || got_l[0] !== 1'b0) begin
        failures++; $display("FAIL dblk_word0 got=%h/%0d/%b exp=e6a364d2/4/0", got_w[0], got_b[0], got_l[0]); end
      checks++; if (got_w[1] !== 32'hC000_0000 || got_b[1] != 1 || got_l[1] !== 1'b1) begin
        failures++; $display("FAIL dblk_word1 got=%h/%0d/%b exp=c0000000/1/1", got_w[1], got_b[1], got_l[1]); end
    end
  endtask

  task automatic test_long_codes();
    int w;
    start_slice(65534, 2, 7, 9, 12, -26, 2, 7, -8);
    send_beat(1'b1, 32'd0, 1, 1'b0, 1'b0, w);
    send_beat(1'b1, 32'd0, 1, 1'b0, 1'b0, w);
    send_beat(1'b0, 32'hDEADBEEF, 32, 1'b0, 1'b0, w);
    send_beat(1'b0, 32'hF800_0000, 5, 1'b1, 1'b0, w);
    send_beat(1'b1, 32'd0, 1, 1'b0, 1'b0, w);
    send_beat(1'b0, 32'h1234_5678, 13, 1'b1, 1'b1, w);
    wait_last();
    model_hdr(65534, 2, 7, 9, 12, -26, 2, 7, -8);
    put_ue(2); put_u(32'hDEADBEEF, 32); put_u(32'h1F, 5);
    put_ue(1); put_u(32'h1234_5678 >> 19, 13);
    model_end();
    checks++;
    if (got_w.size() != exp_w.size()) begin failures++; $display("FAIL long_count got=%0d exp=%0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_b[i] != exp_b[i] || got_l[i] !== (i == exp_w.size() - 1)) begin
        failures++;
        $display("FAIL long_word%0d got=%h/%0d/%b exp=%h/%0d/%b", i, got_w[i], got_b[i], got_l[i],
                 exp_w[i], exp_b[i], (i == exp_w.size() - 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    logic [31:0] held;
    start_slice(0, 0, 0, 3, 5, 0, 1, 0, 0);
    fork
      begin
        send_beat(1'b1, 32'd0, 1, 1'b0, 1'b0, w2);
        send_beat(1'b0, 32'hCAFEF00D, 32, 1'b0, 1'b0, w1);
        checks++; if (w1 < 1) begin failures++; $display("FAIL stall_first_chunk_wait got=%0d exp=>=1", w1); end
        send_beat(1'b0, 32'hB700_0000, 8, 1'b1, 1'b0, w2);
        send_beat(1'b1, 32'd0, 1, 1'b0, 1'b1, w2);
      end
      begin
        int n = 0;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (!out_valid) begin
          failures++; $display("FAIL stall_no_word got=0 exp=1");
        end else begin
          out_ready = 1'b0;
          @(negedge clk); held = out_data;
          repeat (10) begin
            @(negedge clk);
            checks++;
            if (out_data !== held || out_valid !== 1'b1) begin
              failures++; $display("FAIL stall_hold got=%h/%b exp=%h/1", out_data, out_valid, held);
            end
          end
          out_ready = 1'b1;
        end
      end
    join
    wait_last();
    model_hdr(0, 0, 0, 3, 5, 0, 1, 0, 0);
    put_ue(1); put_u(32'hCAFEF00D, 32); put_u(32'hB7, 8); put_ue(1);
    model_end();
    checks++;
    if (got_w.size() != exp_w.size()) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_b[i] != exp_b[i] || got_l[i] !== (i == exp_w.size() - 1)) begin
        failures++;
        $display("FAIL stall_word%0d got=%h/%0d/%b exp=%h/%0d/%b", i, got_w[i], got_b[i], got_l[i],
                 exp_w[i], exp_b[i], (i == exp_w.size() - 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    start_slice(0, 0, 0, 3, 5, 0, 1, 0, 0);
    send_beat(1'b0, 32'hFFFF_FFFF, 32, 1'b0, 1'b0, w);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || mb_ready !== 1'b0) begin
      failures++; $display("FAIL midrst_ctrl got=%b%b exp=00", busy, mb_ready); end
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_bytes !== 3'd0 || out_data !== '0) begin
      failures++; $display("FAIL midrst_out got=%b/%b/%0d/%h exp=0/0/0/0", out_valid, out_last, out_bytes, out_data); end
    reset = 1'b1;
    @(posedge clk); #1;
    test_single_mb("after_rst");
  endtask

  initial begin
    test_reset();
    test_single_mb("single");
    test_skip_run();
    test_deblock();
    test_long_codes();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
